// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, column/row one-hot encodings and the
// mapping from a sampled (column, row) position to its key code.
package keypad_pkg;

    localparam int NUM_KEYS = 12;

    typedef logic [NUM_KEYS-1:0] key_mask_t;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    localparam logic [2:0] COL_1 = 3'b001;
    localparam logic [2:0] COL_2 = 3'b010;
    localparam logic [2:0] COL_3 = 3'b100;

    localparam logic [3:0] ROW_1 = 4'b0001;
    localparam logic [3:0] ROW_2 = 4'b0010;
    localparam logic [3:0] ROW_3 = 4'b0100;
    localparam logic [3:0] ROW_4 = 4'b1000;

    // row_idx 3 is the top row (1,2,3), row_idx 0 the bottom row (*,0,#)
    function automatic logic [3:0] key_code(input logic [2:0] col, input logic [1:0] row_idx);
        logic [3:0] code;
        code = KEY_0;
        case (col)
            COL_1: begin
                case (row_idx)
                    2'd3:    code = KEY_3;
                    2'd2:    code = KEY_6;
                    2'd1:    code = KEY_9;
                    default: code = KEY_HASH;
                endcase
            end
            COL_2: begin
                case (row_idx)
                    2'd3:    code = KEY_2;
                    2'd2:    code = KEY_5;
                    2'd1:    code = KEY_8;
                    default: code = KEY_0;
                endcase
            end
            default: begin
                case (row_idx)
                    2'd3:    code = KEY_1;
                    2'd2:    code = KEY_4;
                    2'd1:    code = KEY_7;
                    default: code = KEY_STAR;
                endcase
            end
        endcase
        return code;
    endfunction

    function automatic key_mask_t column_mask(input logic [2:0] col, input logic [3:0] rows);
        key_mask_t mask;
        mask = '0;
        for (int r = 0; r < 4; r++) begin
            if (rows[r]) begin
                mask[key_code(col, 2'(r))] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous FIFO with registered head; push and pop in one cycle are both
// honoured even when full, so a full FIFO can still accept while draining.
module keypad_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (cnt_q == CNT_FULL);
    assign empty_o   = (cnt_q == '0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/keypad_key_debouncer.sv
// Assembles 3x4 keypad frames, debounces them over STABLE_FRAMES scans and queues one
// code per new press; full FIFO holds presses in a pending mask rather than dropping them.
module keypad_key_debouncer
    import keypad_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        scanClock,
    input  logic        reset,
    input  logic [2:0]  activeColumn,
    input  logic [3:0]  activeRow,
    output logic [3:0]  keyCode,
    output logic        keyValid,
    input  logic        keyReady,
    output logic [11:0] keysHeld,
    output logic        pressMerged
);

    localparam logic [3:0] STABLE_CNT    = 4'(STABLE_FRAMES);
    localparam logic [3:0] STABLE_CNT_M1 = 4'(STABLE_FRAMES - 1);

    logic [3:0] col1_rows_q;
    logic [3:0] col2_rows_q;
    logic       col1_seen_q;
    logic       col2_seen_q;
    key_mask_t  cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    key_mask_t  held_q, held_d;
    key_mask_t  pending_q, pending_d;
    logic       merged_q, merged_d;

    logic       frame_done;
    key_mask_t  frame;
    key_mask_t  new_press;
    key_mask_t  dispatch_clr;
    logic [3:0] push_code;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;

    assign frame_done = (activeColumn == COL_3) && col1_seen_q && col2_seen_q;
    assign frame      = column_mask(COL_1, col1_rows_q)
                      | column_mask(COL_2, col2_rows_q)
                      | column_mask(COL_3, activeRow);

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        new_press = '0;
        if (frame_done) begin
            if (frame == cand_q) begin
                if (cnt_q < STABLE_CNT) begin
                    cnt_d = cnt_q + 4'd1;
                end
                // Only the edge that reaches the threshold updates the held state
                if (cnt_q == STABLE_CNT_M1) begin
                    held_d    = cand_q;
                    new_press = cand_q & ~held_q;
                end
            end else begin
                cand_d = frame;
                cnt_d  = 4'd1;
            end
        end
    end

    always_comb begin
        push_code = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_code = 4'(i);
            end
        end
    end

    assign fifo_pop     = keyValid && keyReady;
    assign fifo_push    = (pending_q != '0) && (!fifo_full || fifo_pop);
    assign dispatch_clr = fifo_push ? (key_mask_t'(1) << push_code) : '0;

    // A bit leaving for the FIFO this cycle makes a simultaneous press a fresh event
    always_comb begin
        pending_d = (pending_q & ~dispatch_clr) | new_press;
        merged_d  = |(new_press & pending_q & ~dispatch_clr);
    end

    always_ff @(posedge scanClock or posedge reset) begin
        if (reset) begin
            col1_rows_q <= '0;
            col2_rows_q <= '0;
            col1_seen_q <= 1'b0;
            col2_seen_q <= 1'b0;
            cand_q      <= '0;
            cnt_q       <= '0;
            held_q      <= '0;
            pending_q   <= '0;
            merged_q    <= 1'b0;
        end else begin
            if (activeColumn == COL_1) begin
                col1_rows_q <= activeRow;
                col1_seen_q <= 1'b1;
            end else if (activeColumn == COL_2) begin
                col2_rows_q <= activeRow;
                col2_seen_q <= 1'b1;
            end else begin
                col1_seen_q <= 1'b0;
                col2_seen_q <= 1'b0;
            end
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            pending_q <= pending_d;
            merged_q  <= merged_d;
        end
    end

    keypad_event_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk        (scanClock),
        .rst        (reset),
        .push_i     (fifo_push),
        .push_dat_i (push_code),
        .pop_i      (fifo_pop),
        .pop_dat_o  (keyCode),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign keyValid    = !fifo_empty;
    assign keysHeld    = held_q;
    assign pressMerged = merged_q;

endmodule

// File: tb/tb_keypad_key_debouncer.sv
// Directed scoreboard bench for keypad_key_debouncer: stimulus queues expected key
// codes, a negedge monitor pops and compares them on every accepted handshake.
module tb_keypad_key_debouncer;

    logic        scanClock;
    logic        reset;
    logic [2:0]  activeColumn;
    logic [3:0]  activeRow;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyReady;
    logic [11:0] keysHeld;
    logic        pressMerged;

    int          n_vec;
    int          n_err;
    int          merge_pulses;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;
    logic [11:0] grow_masks [5];

    keypad_key_debouncer #(
        .STABLE_FRAMES (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .scanClock    (scanClock),
        .reset        (reset),
        .activeColumn (activeColumn),
        .activeRow    (activeRow),
        .keyCode      (keyCode),
        .keyValid     (keyValid),
        .keyReady     (keyReady),
        .keysHeld     (keysHeld),
        .pressMerged  (pressMerged)
    );

    initial begin
        scanClock = 1'b0;
        forever #5 scanClock = ~scanClock;
    end

    // Keypad layout: col1 = 3,6,9,#  col2 = 2,5,8,0  col3 = 1,4,7,*  (top row in bit 3)
    function automatic logic [3:0] rows_for(input int c, input logic [11:0] m);
        logic [3:0] r;
        case (c)
            0:       r = {m[3], m[6], m[9], m[11]};
            1:       r = {m[2], m[5], m[8], m[0]};
            default: r = {m[1], m[4], m[7], m[10]};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_col(input int c, input logic [11:0] m);
        activeColumn = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b100;
        activeRow    = rows_for(c, m);
        @(posedge scanClock);
        #2;
    endtask

    task automatic run_frame(input logic [11:0] m);
        for (int c = 0; c < 3; c++) begin
            step_col(c, m);
        end
    endtask

    always @(negedge scanClock) begin
        if (!reset) begin
            if (pressMerged) merge_pulses++;
            if (keyValid && keyReady) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got code 0x%0h, expected no event", keyCode);
                end else begin
                    exp_code = exp_q.pop_front();
                    if (keyCode !== exp_code) begin
                        n_err++;
                        $display("FAIL event_code: got 0x%0h, expected 0x%0h", keyCode, exp_code);
                    end
                end
            end
        end
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        merge_pulses = 0;
        reset        = 1'b1;
        keyReady     = 1'b1;
        activeColumn = 3'b000;
        activeRow    = 4'b0000;
        grow_masks   = '{12'h002, 12'h006, 12'h00E, 12'h01E, 12'h05E};

        repeat (2) @(posedge scanClock);
        #2;
        check("rst_keyValid", keyValid, 0);
        check("rst_keyCode", keyCode, 0);
        check("rst_keysHeld", keysHeld, 0);
        check("rst_pressMerged", pressMerged, 0);
        reset = 1'b0;

        // Key 5 held for 6 frames
        exp_q.push_back(4'd5);
        for (int f = 1; f <= 3; f++) begin
            run_frame(12'h020);
            check("k5_held_early", keysHeld, 0);
        end
        run_frame(12'h020);
        check("k5_held_edge12", keysHeld, 12'h020);
        check("k5_valid_edge12", keyValid, 0);
        step_col(0, 12'h020);
        check("k5_valid_edge13", keyValid, 1);
        check("k5_code_edge13", keyCode, 5);
        step_col(1, 12'h020);
        step_col(2, 12'h020);
        run_frame(12'h020);
        repeat (5) run_frame(12'h000);
        check("k5_released", keysHeld, 0);

        // Key 7 bouncing on alternate frames
        for (int f = 0; f < 10; f++) begin
            run_frame((f % 2 == 0) ? 12'h080 : 12'h000);
            check("k7_bounce_held", keysHeld, 0);
        end
        repeat (4) run_frame(12'h000);

        // * and # together
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hB);
        repeat (4) run_frame(12'hC00);
        check("starhash_held", keysHeld, 12'hC00);
        step_col(0, 12'hC00);
        check("starhash_valid1", keyValid, 1);
        check("starhash_code1", keyCode, 4'hA);
        step_col(1, 12'hC00);
        check("starhash_valid2", keyValid, 1);
        check("starhash_code2", keyCode, 4'hB);
        step_col(2, 12'hC00);
        repeat (5) run_frame(12'h000);
        check("starhash_released", keysHeld, 0);

        // Backpressure: 1,2,3,4 fill the FIFO, 6 waits in pending
        keyReady = 1'b0;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd6);
        for (int i = 0; i < 5; i++) begin
            repeat (4) run_frame(grow_masks[i]);
            check("seq_held", keysHeld, grow_masks[i]);
        end
        run_frame(12'h05E);
        check("seq_valid_stalled", keyValid, 1);
        check("seq_code_stalled", keyCode, 1);

        // Release and re-press 6 while it is still pending
        repeat (4) run_frame(12'h01E);
        check("merge_held_release", keysHeld, 12'h01E);
        check("merge_no_pulse_yet", pressMerged, 0);
        repeat (3) run_frame(12'h05E);
        check("merge_held_pre", keysHeld, 12'h01E);
        run_frame(12'h05E);
        check("merge_held_repress", keysHeld, 12'h05E);
        check("merge_pulse", pressMerged, 1);
        step_col(0, 12'h05E);
        check("merge_pulse_end", pressMerged, 0);
        check("merge_code_still", keyCode, 1);
        step_col(1, 12'h05E);
        step_col(2, 12'h05E);
        keyReady = 1'b1;
        repeat (3) run_frame(12'h05E);
        repeat (5) run_frame(12'h000);
        check("drain_released", keysHeld, 0);
        check("drain_valid", keyValid, 0);

        // Reset mid-frame while key 9 is held and an event is presented
        keyReady = 1'b0;
        repeat (5) run_frame(12'h200);
        check("k9_pre_valid", keyValid, 1);
        check("k9_pre_code", keyCode, 9);
        step_col(0, 12'h200);
        reset = 1'b1;
        #1;
        check("midrst_keyValid", keyValid, 0);
        check("midrst_keyCode", keyCode, 0);
        check("midrst_keysHeld", keysHeld, 0);
        check("midrst_pressMerged", pressMerged, 0);
        @(posedge scanClock);
        #2;
        reset    = 1'b0;
        keyReady = 1'b1;
        exp_q.push_back(4'd9);
        repeat (3) run_frame(12'h200);
        check("k9_held_early", keysHeld, 0);
        run_frame(12'h200);
        check("k9_held_edge12", keysHeld, 12'h200);
        repeat (2) run_frame(12'h200);
        repeat (5) run_frame(12'h000);
        check("k9_released", keysHeld, 0);

        check("events_outstanding", exp_q.size(), 0);
        check("merge_pulse_count", merge_pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
